// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the writeback sources and regfile_wb_arbiter: per-source request handshake,
// the registered register-file write port and the in-flight destination mask.
interface regfile_wb_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [N_REQ-1:0]        req_valid;
  logic [ADDR_W*N_REQ-1:0] req_addr;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    RegWrite_en;
  logic [ADDR_W-1:0]       RegWrite;
  logic [DATA_W-1:0]       RegWriteData;
  logic [(2**ADDR_W)-1:0]  pend_mask;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, RegWrite_en, RegWrite, RegWriteData, pend_mask
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, RegWrite_en, RegWrite, RegWriteData, pend_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares one registered register-file write port among N_REQ writeback sources via 1-entry holds.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; default is round-robin.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 CLK_in,
  input  logic                 RST_in,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] in_addr   [N_REQ];
  logic [DATA_W-1:0] in_data   [N_REQ];
  logic [N_REQ-1:0]  addr_nz;
  logic [N_REQ-1:0]  hold_v;
  logic [ADDR_W-1:0] hold_addr [N_REQ];
  logic [DATA_W-1:0] hold_data [N_REQ];

  logic [N_REQ-1:0]  grant;
  logic              grant_any;
  logic [IDX_W-1:0]  grant_idx;

  logic [N_REQ-1:0]  hold_hit;
  logic [N_REQ-1:0]  lower_hit;
  logic [N_REQ-1:0]  ready_base;
  logic [N_REQ-1:0]  ready;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   pend;

  // Per-source holding register; a fresh accept takes priority over the clear caused by a grant.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_src
    logic              hold_v_q, hold_v_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              take;

    assign in_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign in_data[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    assign addr_nz[gi] = |in_addr[gi];
    assign take        = bus.req_valid[gi] & ready[gi];

    always_comb begin
      hold_v_d    = hold_v_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      if (grant[gi]) begin
        hold_v_d = 1'b0;
      end
      if (take && addr_nz[gi]) begin
        hold_v_d    = 1'b1;
        hold_addr_d = in_addr[gi];
        hold_data_d = in_data[gi];
      end
    end

    always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
        hold_v_q    <= 1'b0;
        hold_addr_q <= '0;
        hold_data_q <= '0;
      end else begin
        hold_v_q    <= hold_v_d;
        hold_addr_q <= hold_addr_d;
        hold_data_q <= hold_data_d;
      end
    end

    assign hold_v[gi]    = hold_v_q;
    assign hold_addr[gi] = hold_addr_q;
    assign hold_data[gi] = hold_data_q;
  end

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_any && hold_v[k]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps; the pointer moves past the winner only on a grant.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_any && hold_v[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // A nonzero destination is refused while another hold owns it, or while a lower-index source
  // is being accepted for it this cycle; this keeps same-address writes out of the holds at once.
  always_comb begin
    hold_hit   = '0;
    lower_hit  = '0;
    ready_base = '0;
    ready      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (j != i && hold_v[j] && hold_addr[j] == in_addr[i]) begin
          hold_hit[i] = 1'b1;
        end
      end
      ready_base[i] = (~hold_v[i] | grant[i]) & ~(addr_nz[i] & hold_hit[i]);
    end
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < i; j++) begin
        if (bus.req_valid[j] && ready_base[j] && in_addr[j] == in_addr[i]) begin
          lower_hit[i] = 1'b1;
        end
      end
      ready[i] = ready_base[i] & ~(addr_nz[i] & lower_hit[i]) & ~RST_in;
    end
  end

  always_comb begin
    we_d    = grant_any;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant_any) begin
      waddr_d = hold_addr[grant_idx];
      wdata_d = hold_data[grant_idx];
    end
  end

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // In-flight destinations: every valid hold plus the write currently on the port.
  always_comb begin
    pend = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (hold_v[i]) begin
        pend[hold_addr[i]] = 1'b1;
      end
    end
    if (we_q) begin
      pend[waddr_q] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign bus.req_ready    = ready;
  assign bus.RegWrite_en  = we_q;
  assign bus.RegWrite     = waddr_q;
  assign bus.RegWriteData = wdata_q;
  assign bus.pend_mask    = pend;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: cycle-by-cycle vector table plus a per-address write scoreboard,
// followed by a hand-written mid-operation reset sequence.
module tb_regfile_wb_arbiter;
  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NV     = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK_in (clk),
    .RST_in (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic        rst;
    logic [2:0]  valid;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] base;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_pend;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vec [NV];
  wr_t  sb_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_row(input int r, input logic rs, input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] b, input logic [2:0] er, input logic ew,
                         input logic [4:0] ea, input logic [31:0] ep);
    vec[r].rst       = rs;
    vec[r].valid     = v;
    vec[r].a0        = a0;
    vec[r].a1        = a1;
    vec[r].a2        = a2;
    vec[r].base      = b;
    vec[r].exp_ready = er;
    vec[r].exp_we    = ew;
    vec[r].exp_waddr = ea;
    vec[r].exp_pend  = ep;
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] b);
    bus.req_valid = v;
    bus.req_addr  = {a2, a1, a0};
    bus.req_data  = {b + 32'd2, b + 32'd1, b};
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb_q.push_back(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_we", 32'(bus.RegWrite_en), 32'd0);
    check("rst_waddr", 32'(bus.RegWrite), 32'd0);
    check("rst_wdata", bus.RegWriteData, 32'd0);
    check("rst_pend", bus.pend_mask, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Each issued write must match the oldest outstanding accept to the same address.
  always @(negedge clk) begin
    int idx;
    idx = -1;
    if (!rst && bus.RegWrite_en === 1'b1) begin
      for (int k = 0; k < sb_q.size(); k++) begin
        if (idx < 0 && sb_q[k].addr == bus.RegWrite) idx = k;
      end
      checks++;
      if (idx < 0) begin
        failures++;
        $display("FAIL write_unexpected actual addr=%0d data=%h required=no write",
                 bus.RegWrite, bus.RegWriteData);
      end else begin
        if (bus.RegWriteData !== sb_q[idx].data) begin
          failures++;
          $display("FAIL write_data addr=%0d actual=%h required=%h",
                   bus.RegWrite, bus.RegWriteData, sb_q[idx].data);
        end
        sb_q.delete(idx);
      end
    end
  end

  initial begin
    // single write
    set_row(0,  1, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 3'b111, 0, 5'd0, 32'h0);
    set_row(1,  0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,        3'b111, 0, 5'd0, 32'h20);
    set_row(2,  0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,        3'b111, 1, 5'd5, 32'h20);
    set_row(3,  0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,        3'b111, 0, 5'd5, 32'h0);
    // zero address from src1
    set_row(4,  0, 3'b010, 5'd0, 5'd0, 5'd0, 32'h1233,     3'b111, 0, 5'd5, 32'h0);
    set_row(5,  0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,        3'b111, 0, 5'd5, 32'h0);
    set_row(6,  0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,        3'b111, 0, 5'd5, 32'h0);
    // fairness: all sources valid on addrs 1/2/3
    set_row(7,  1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7000_0000, 3'b111, 0, 5'd0, 32'h0);
    set_row(8,  0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7100_0000, 3'b001, 0, 5'd0, 32'hE);
`ifdef ARB_FIXED_PRIO_EN
    set_row(9,  0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7200_0000, 3'b001, 1, 5'd1, 32'hE);
    set_row(10, 0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7300_0000, 3'b001, 1, 5'd1, 32'hE);
    set_row(11, 0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7400_0000, 3'b001, 1, 5'd1, 32'hE);
    set_row(12, 0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7500_0000, 3'b001, 1, 5'd1, 32'hE);
    set_row(13, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b001, 1, 5'd1, 32'hE);
    set_row(14, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b011, 1, 5'd1, 32'hE);
    set_row(15, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 1, 5'd2, 32'hC);
    set_row(16, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 1, 5'd3, 32'h8);
    set_row(17, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 0, 5'd3, 32'h0);
`else
    set_row(9,  0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7200_0000, 3'b010, 1, 5'd1, 32'hE);
    set_row(10, 0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7300_0000, 3'b100, 1, 5'd2, 32'hE);
    set_row(11, 0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7400_0000, 3'b001, 1, 5'd3, 32'hE);
    set_row(12, 0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h7500_0000, 3'b010, 1, 5'd1, 32'hE);
    set_row(13, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b100, 1, 5'd2, 32'hE);
    set_row(14, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b101, 1, 5'd3, 32'hE);
    set_row(15, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 1, 5'd1, 32'h6);
    set_row(16, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 1, 5'd2, 32'h4);
    set_row(17, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 0, 5'd2, 32'h0);
`endif
    // WAW on addr 7
    set_row(18, 1, 3'b001, 5'd7, 5'd7, 5'd0, 32'h1800_0000, 3'b101, 0, 5'd0, 32'h0);
    set_row(19, 0, 3'b010, 5'd0, 5'd7, 5'd0, 32'h1900_0000, 3'b101, 0, 5'd0, 32'h80);
    set_row(20, 0, 3'b010, 5'd0, 5'd7, 5'd0, 32'h2000_0000, 3'b111, 1, 5'd7, 32'h80);
    set_row(21, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 0, 5'd7, 32'h80);
    set_row(22, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 1, 5'd7, 32'h80);
    set_row(23, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 0, 5'd7, 32'h0);
    // same-cycle conflict on addr 9
    set_row(24, 0, 3'b110, 5'd0, 5'd9, 5'd9, 32'h2400_0000, 3'b011, 0, 5'd7, 32'h0);
    set_row(25, 0, 3'b100, 5'd0, 5'd9, 5'd9, 32'h2500_0000, 3'b011, 0, 5'd7, 32'h200);
    set_row(26, 0, 3'b100, 5'd0, 5'd0, 5'd9, 32'h2600_0000, 3'b111, 1, 5'd9, 32'h200);
    set_row(27, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 0, 5'd9, 32'h200);
    set_row(28, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 1, 5'd9, 32'h200);
    set_row(29, 0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,         3'b111, 0, 5'd9, 32'h0);

    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
    @(posedge clk);
    #1;

    for (int r = 0; r < NV; r++) begin
      if (vec[r].rst) do_reset();
      drive(vec[r].valid, vec[r].a0, vec[r].a1, vec[r].a2, vec[r].base);
      if (vec[r].valid[0] && vec[r].exp_ready[0] && vec[r].a0 != 5'd0) push_wr(vec[r].a0, vec[r].base);
      if (vec[r].valid[1] && vec[r].exp_ready[1] && vec[r].a1 != 5'd0) push_wr(vec[r].a1, vec[r].base + 32'd1);
      if (vec[r].valid[2] && vec[r].exp_ready[2] && vec[r].a2 != 5'd0) push_wr(vec[r].a2, vec[r].base + 32'd2);
      @(negedge clk);
      check($sformatf("row%0d_ready", r), 32'(bus.req_ready), 32'(vec[r].exp_ready));
      check($sformatf("row%0d_we", r), 32'(bus.RegWrite_en), 32'(vec[r].exp_we));
      check($sformatf("row%0d_waddr", r), 32'(bus.RegWrite), 32'(vec[r].exp_waddr));
      check($sformatf("row%0d_pend", r), bus.pend_mask, vec[r].exp_pend);
      @(posedge clk);
      #1;
    end

    // Mid-operation reset: holds full and a write on the port, reset pulsed between edges.
    drive(3'b111, 5'd4, 5'd5, 5'd6, 32'h4000_0000);
    push_wr(5'd4, 32'h4000_0000);
    @(posedge clk);
    #1;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    check("midrst_pend_full", bus.pend_mask, 32'h70);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check("midrst_we_before", 32'(bus.RegWrite_en), 32'd1);
    check("midrst_pend_before", bus.pend_mask, 32'h70);
    rst = 1'b1;
    #1;
    check("midrst_we_now", 32'(bus.RegWrite_en), 32'd0);
    check("midrst_pend_now", bus.pend_mask, 32'd0);
    check("midrst_ready_now", 32'(bus.req_ready), 32'd0);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("postrst_we%0d", c), 32'(bus.RegWrite_en), 32'd0);
    end
    check("postrst_pend", bus.pend_mask, 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
